// File: rtl/bht_update_ctrl.sv
// Write-side scheduler for the branch history cache: buffers resolved-branch
// updates, issues one write per cycle with same-index bubbles, and sequences flushes.
module bht_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int PC_WIDTH     = 10,
    parameter int IDX_WIDTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [PC_WIDTH-1:0]        upd_pc,
    input  logic                       upd_taken,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic                       cache_we,
    output logic [PC_WIDTH-1:0]        cache_update_pc,
    output logic                       cache_branch_taken,
    output logic                       cache_rst,
    input  logic [PC_WIDTH-1:0]        fetch_pc,
    input  logic                       pred_hit,
    input  logic [2:0]                 pred_history,
    output logic                       predict_taken,
    output logic                       pred_stale,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
    } upd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUBBLE, FLUSH} state_t;

    upd_t                fifo [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    flush_cnt;
    state_t              state, state_nxt;
    logic                push, pop;
    upd_t                head;
    logic [IDX_WIDTH-1:0] next_head_idx;
    logic                next_head_vld;
    logic [DEPTH-1:0]    ent_vld;
    logic [PC_WIDTH-IDX_WIDTH-1:0] unused_fetch_hi;

    assign unused_fetch_hi = fetch_pc[PC_WIDTH-1:IDX_WIDTH];

    assign flush_busy = (state == FLUSH);
    assign cache_rst  = flush_busy;
    assign upd_ready  = ~rst & ~flush_busy & ~flush_req & (occupancy < OCC_W'(DEPTH));
    assign push       = upd_valid & upd_ready;
    assign pop        = (state == ISSUE) & (occupancy != '0) & ~flush_req;
    assign head       = fifo[rd_ptr];

    // With a single entry left, a same-cycle push becomes the next head.
    assign next_head_vld = (occupancy > OCC_W'(1)) | push;
    assign next_head_idx = (occupancy > OCC_W'(1)) ? fifo[rd_ptr + PTR_W'(1)].pc[IDX_WIDTH-1:0]
                                                   : upd_pc[IDX_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (push) state_nxt = ISSUE;
            ISSUE: begin
                if (!pop || !next_head_vld)
                    state_nxt = IDLE;
                else if (next_head_idx == head.pc[IDX_WIDTH-1:0])
                    state_nxt = BUBBLE;
                else
                    state_nxt = ISSUE;
            end
            BUBBLE: state_nxt = ISSUE;
            FLUSH:  if (flush_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_req) state_nxt = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            occupancy          <= '0;
            flush_cnt          <= '0;
            cache_we           <= 1'b0;
            cache_update_pc    <= '0;
            cache_branch_taken <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_req) begin
                // Drop the queue and cancel any write registered this edge.
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
                cache_we  <= 1'b0;
                flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + OCC_W'(1);
                    2'b01:   occupancy <= occupancy - OCC_W'(1);
                    default: occupancy <= occupancy;
                endcase
                cache_we <= pop;
                if (pop) begin
                    cache_update_pc    <= head.pc;
                    cache_branch_taken <= head.taken;
                end
                if (state == FLUSH && flush_cnt != '0)
                    flush_cnt <= flush_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{pc: upd_pc, taken: upd_taken};
    end

    // Taken when at least two of the three history bits are set.
    assign predict_taken = pred_hit & ~flush_busy &
                           ((pred_history[0] & pred_history[1]) |
                            (pred_history[0] & pred_history[2]) |
                            (pred_history[1] & pred_history[2]));

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr} < occupancy);
    end

    always_comb begin
        pred_stale = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i] && fifo[i].pc[IDX_WIDTH-1:0] == fetch_pc[IDX_WIDTH-1:0])
                pred_stale = 1'b1;
        if (cache_we && cache_update_pc[IDX_WIDTH-1:0] == fetch_pc[IDX_WIDTH-1:0])
            pred_stale = 1'b1;
        if (flush_busy)
            pred_stale = 1'b0;
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed self-checking bench for bht_update_ctrl (DEPTH=4, FLUSH_CYCLES=2).
module tb_bht_update_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       upd_valid, upd_ready, upd_taken;
    logic [9:0] upd_pc;
    logic       flush_req, flush_busy;
    logic       cache_we, cache_branch_taken, cache_rst;
    logic [9:0] cache_update_pc;
    logic [9:0] fetch_pc;
    logic       pred_hit;
    logic [2:0] pred_history;
    logic       predict_taken, pred_stale;
    logic [2:0] occupancy;

    int total = 0;
    int bad   = 0;
    int b2b_err = 0;
    logic saw_full;
    logic prev_we = 1'b0;
    logic [3:0] prev_idx = '0;
    logic [10:0] wq [$];

    bht_update_ctrl #(.DEPTH(4), .PC_WIDTH(10), .IDX_WIDTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .cache_we(cache_we), .cache_update_pc(cache_update_pc),
        .cache_branch_taken(cache_branch_taken), .cache_rst(cache_rst),
        .fetch_pc(fetch_pc), .pred_hit(pred_hit), .pred_history(pred_history),
        .predict_taken(predict_taken), .pred_stale(pred_stale), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Write log; also flags two consecutive write cycles to one index.
    always @(negedge clk) begin
        if (cache_we) begin
            wq.push_back({cache_update_pc, cache_branch_taken});
            if (prev_we && prev_idx == cache_update_pc[3:0]) b2b_err <= b2b_err + 1;
        end
        prev_we  <= cache_we;
        prev_idx <= cache_update_pc[3:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one update and hold it until accepted (bounded).
    task automatic push_one(input logic [9:0] pc, input logic tk);
        int n = 0;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
        #1;
        while (!upd_ready && n < 50) begin
            if (occupancy == 3'd4) saw_full = 1'b1;
            tick(); n++;
        end
        total++;
        if (!upd_ready) begin
            bad++; $display("FAIL push_timeout pc=%h ready=%b want 1", pc, upd_ready);
        end
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", upd_ready); end
        total++; if ({cache_we, cache_rst, flush_busy, cache_branch_taken} !== 4'b0) begin
            bad++; $display("FAIL rst_ctl got=%b want=0000", {cache_we, cache_rst, flush_busy, cache_branch_taken}); end
        total++; if (occupancy !== 3'd0 || cache_update_pc !== 10'd0) begin
            bad++; $display("FAIL rst_occ_pc got=%0d/%h want=0/000", occupancy, cache_update_pc); end
        rst = 1'b0; #1;
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", upd_ready); end
    endtask

    task automatic test_basic_stream();
        wq.delete();
        upd_valid = 1'b1; upd_pc = 10'h013; upd_taken = 1'b1;
        tick();
        total++; if (cache_we !== 1'b0 || occupancy !== 3'd1) begin
            bad++; $display("FAIL basic_n got we=%b occ=%0d want 0/1", cache_we, occupancy); end
        upd_pc = 10'h025; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        total++; if ({cache_we, cache_update_pc, cache_branch_taken} !== {1'b1, 10'h013, 1'b1} || occupancy !== 3'd1) begin
            bad++; $display("FAIL basic_n1 got we=%b pc=%h t=%b occ=%0d want 1/013/1/1",
                            cache_we, cache_update_pc, cache_branch_taken, occupancy); end
        tick();
        total++; if ({cache_we, cache_update_pc, cache_branch_taken} !== {1'b1, 10'h025, 1'b0} || occupancy !== 3'd0) begin
            bad++; $display("FAIL basic_n2 got we=%b pc=%h t=%b occ=%0d want 1/025/0/0",
                            cache_we, cache_update_pc, cache_branch_taken, occupancy); end
        tick();
        total++; if (cache_we !== 1'b0 || occupancy !== 3'd0 || upd_ready !== 1'b1) begin
            bad++; $display("FAIL basic_idle got we=%b occ=%0d rdy=%b want 0/0/1", cache_we, occupancy, upd_ready); end
    endtask

    task automatic test_back_to_back();
        upd_valid = 1'b1; upd_pc = 10'h013; upd_taken = 1'b1;
        tick();
        upd_pc = 10'h053; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        total++; if (cache_we !== 1'b1 || cache_update_pc !== 10'h013) begin
            bad++; $display("FAIL b2b_n1 got we=%b pc=%h want 1/013", cache_we, cache_update_pc); end
        tick();
        total++; if (cache_we !== 1'b0 || occupancy !== 3'd1) begin
            bad++; $display("FAIL b2b_bubble got we=%b occ=%0d want 0/1", cache_we, occupancy); end
        tick();
        total++; if (cache_we !== 1'b1 || cache_update_pc !== 10'h053 || occupancy !== 3'd0) begin
            bad++; $display("FAIL b2b_n3 got we=%b pc=%h occ=%0d want 1/053/0", cache_we, cache_update_pc, occupancy); end
        tick();
        total++; if (cache_we !== 1'b0) begin bad++; $display("FAIL b2b_deassert got we=%b want 0", cache_we); end
    endtask

    task automatic test_full_burst();
        logic [9:0] pc;
        wq.delete(); saw_full = 1'b0;
        for (int k = 0; k < 8; k++) push_one(10'h006 + 10'(k << 4), k[0]);
        for (int k = 0; k < 30; k++) tick();
        total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL full_ready_drop got=%b want=1", saw_full); end
        total++; if (wq.size() != 8) begin bad++; $display("FAIL full_count got=%0d want=8", wq.size()); end
        for (int k = 0; k < 8 && k < wq.size(); k++) begin
            pc = 10'h006 + 10'(k << 4);
            total++; if (wq[k] !== {pc, k[0]}) begin
                bad++; $display("FAIL full_order[%0d] got=%h want=%h", k, wq[k], {pc, k[0]}); end
        end
        total++; if (b2b_err != 0) begin bad++; $display("FAIL same_idx_b2b got=%0d want=0", b2b_err); end
    endtask

    task automatic test_flush();
        wq.delete();
        for (int k = 0; k < 5; k++) push_one(10'h00A + 10'(k << 4), 1'b1);
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d want=3", occupancy); end
        flush_req = 1'b1; #1;
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL flush_req_ready got=%b want=0", upd_ready); end
        tick();
        flush_req = 1'b0;
        pred_hit = 1'b1; pred_history = 3'b111; #1;
        total++; if (occupancy !== 3'd0 || cache_we !== 1'b0 || cache_rst !== 1'b1 || flush_busy !== 1'b1 || upd_ready !== 1'b0) begin
            bad++; $display("FAIL flush_c1 got occ=%0d we=%b crst=%b busy=%b rdy=%b want 0/0/1/1/0",
                            occupancy, cache_we, cache_rst, flush_busy, upd_ready); end
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL flush_pred got=%b want=0", predict_taken); end
        tick();
        total++; if (cache_rst !== 1'b1 || flush_busy !== 1'b1 || upd_ready !== 1'b0) begin
            bad++; $display("FAIL flush_c2 got crst=%b busy=%b rdy=%b want 1/1/0", cache_rst, flush_busy, upd_ready); end
        tick();
        total++; if (cache_rst !== 1'b0 || flush_busy !== 1'b0 || upd_ready !== 1'b1) begin
            bad++; $display("FAIL flush_end got crst=%b busy=%b rdy=%b want 0/0/1", cache_rst, flush_busy, upd_ready); end
        for (int k = 0; k < 10; k++) tick();
        total++; if (wq.size() != 2) begin bad++; $display("FAIL flush_discard got writes=%0d want=2", wq.size()); end
    endtask

    task automatic test_predict();
        pred_hit = 1'b1; pred_history = 3'b011; #1;
        total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL pred_011 got=%b want=1", predict_taken); end
        pred_history = 3'b100; #1;
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL pred_100 got=%b want=0", predict_taken); end
        pred_hit = 1'b0; pred_history = 3'b111; #1;
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL pred_miss got=%b want=0", predict_taken); end
        push_one(10'h027, 1'b1);
        fetch_pc = 10'h3F7; #1;
        total++; if (pred_stale !== 1'b1) begin bad++; $display("FAIL stale_queued got=%b want=1", pred_stale); end
        fetch_pc = 10'h028; #1;
        total++; if (pred_stale !== 1'b0) begin bad++; $display("FAIL stale_other got=%b want=0", pred_stale); end
        tick();
        fetch_pc = 10'h3F7; #1;
        total++; if (cache_we !== 1'b1 || pred_stale !== 1'b1) begin
            bad++; $display("FAIL stale_inflight got we=%b stale=%b want 1/1", cache_we, pred_stale); end
        tick();
        total++; if (pred_stale !== 1'b0) begin bad++; $display("FAIL stale_drained got=%b want=0", pred_stale); end
    endtask

    task automatic test_reset_mid_issue();
        wq.delete();
        push_one(10'h001, 1'b0);
        push_one(10'h011, 1'b0);
        push_one(10'h021, 1'b0);
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 10'h0B2; upd_taken = 1'b1; #1;
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", upd_ready); end
        tick();
        total++; if (cache_we !== 1'b0 || occupancy !== 3'd0 || upd_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_edge got we=%b occ=%0d rdy=%b want 0/0/0", cache_we, occupancy, upd_ready); end
        tick();
        rst = 1'b0; #1;
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_resume got=%b want=1", upd_ready); end
        tick();
        upd_valid = 1'b0;
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL rstmid_accept got=%0d want=1", occupancy); end
        for (int k = 0; k < 5; k++) tick();
        total++; if (wq.size() != 2 || wq[0] !== {10'h001, 1'b0} || wq[wq.size()-1] !== {10'h0B2, 1'b1}) begin
            bad++; $display("FAIL rstmid_writes got n=%0d want 2 (001,0B2)", wq.size()); end
    endtask

    initial begin
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; flush_req = 1'b0;
        fetch_pc = '0; pred_hit = 1'b0; pred_history = '0; saw_full = 1'b0;
        test_reset();
        test_basic_stream();
        test_back_to_back();
        test_full_burst();
        test_flush();
        test_predict();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
